// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port switch allocator.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = unsigned'(i);
    return idx;
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Request/grant/credit bundle between the input buffers and one output-port allocator.
interface noc_output_arbiter_if #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4
);
  localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int IDX_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS-1:0]   req;
  logic [NUM_INPUTS-1:0]   req_is_tail;
  logic [NUM_INPUTS-1:0]   disable_turn;
  logic                    credit_in;
  logic [NUM_INPUTS-1:0]   grant;
  logic [IDX_WIDTH-1:0]    grant_idx;
  logic                    send_out;
  logic                    is_tail_out;
  logic [CREDIT_WIDTH-1:0] credits_avail;
  logic                    locked;
  logic                    credit_overflow;

  modport master (
    output req, req_is_tail, disable_turn, credit_in,
    input  grant, grant_idx, send_out, is_tail_out, credits_avail, locked, credit_overflow
  );

  modport slave (
    input  req, req_is_tail, disable_turn, credit_in,
    output grant, grant_idx, send_out, is_tail_out, credits_avail, locked, credit_overflow
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_priority_picker #(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_WIDTH-1:0]  ptr,
  output logic [NUM_INPUTS-1:0] win,
  output logic                  valid
);
  logic [NUM_INPUTS-1:0]   ge_mask;
  logic [2*NUM_INPUTS-1:0] dbl;
  logic                    found;

  // Low half holds only requests at/above ptr; the high half supplies the wrap-around.
  always_comb begin
    ge_mask = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      ge_mask[i] = (i >= int'(ptr));
    dbl   = {req, req & ge_mask};
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*NUM_INPUTS; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        win[(j >= NUM_INPUTS) ? (j - NUM_INPUTS) : j] = 1'b1;
      end
    end
  end

  assign valid = |req;
endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output switch allocator: packet-locked round-robin, downstream credit tracking, turn mask.
module noc_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                 clk_noc,
  input  logic                 rst_n,
  noc_output_arbiter_if.slave  bus
);
  localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int IDX_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  arb_state_e              state_q, state_d;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0]    owner_q, owner_d;
  logic                    overflow_q;

  logic [NUM_INPUTS-1:0]   eligible;
  logic [NUM_INPUTS-1:0]   pick_win;
  logic                    pick_valid;
  logic [NUM_INPUTS-1:0]   grant_c;
  logic [IDX_WIDTH-1:0]    win_idx;
  logic                    fire;
  logic                    tail;
  logic                    has_credit;

  function automatic logic [IDX_WIDTH-1:0] ptr_inc(input logic [IDX_WIDTH-1:0] p);
    return (p == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : p + IDX_WIDTH'(1);
  endfunction

  assign eligible = bus.req & ~bus.disable_turn;

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    grant_c    = '0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    has_credit = (credits_q != '0);
    case (state_q)
      ARB_IDLE:   if (pick_valid && has_credit) grant_c = pick_win;
      // Turn mask is ignored here so a packet that started always drains.
      ARB_LOCKED: if (bus.req[owner_q] && has_credit) grant_c[owner_q] = 1'b1;
      default:    ;
    endcase
    if (!rst_n) grant_c = '0;

    win_idx = IDX_WIDTH'(onehot_to_idx(32'(grant_c)));
    fire    = |grant_c;
    tail    = |(grant_c & bus.req_is_tail);

    if (fire) begin
      if (state_q == ARB_IDLE) begin
        if (tail) rr_ptr_d = ptr_inc(win_idx);
        else begin
          state_d = ARB_LOCKED;
          owner_d = win_idx;
        end
      end else if (tail) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = ptr_inc(owner_q);
      end
    end
  end

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      credits_q  <= CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      case ({fire, bus.credit_in})
        2'b10: credits_q <= credits_q - CREDIT_WIDTH'(1);
        2'b01: begin
          // A credit returned while already full means the downstream count is broken.
          if (credits_q == CREDIT_WIDTH'(FLIT_BUFFER_DEPTH)) overflow_q <= 1'b1;
          else credits_q <= credits_q + CREDIT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.grant           = grant_c;
  assign bus.grant_idx       = win_idx;
  assign bus.send_out        = fire;
  assign bus.is_tail_out     = tail;
  assign bus.credits_avail   = credits_q;
  assign bus.locked          = (state_q == ARB_LOCKED);
  assign bus.credit_overflow = overflow_q;
endmodule
